// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-style computer: program RAM geometry and the
// program-loader state encoding. The RAM and CPU blocks import the same package.
package sap_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int RAM_DEPTH = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/ram_loader.sv
// Program loader: accepts a framed byte stream (LEN, N data bytes, CHK) over a
// valid/ready handshake and writes the data bytes to RAM addresses 0..N-1,
// verifying an 8-bit additive checksum. The CPU is held in reset while active.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous reset, active low
//   prog_mode    - level request to enter/stay in programming mode
//   in_valid     - stream byte valid
//   in_data      - stream byte
//   in_ready     - loader accepts a byte this cycle (depends on state only)
//   wr_en        - registered RAM write strobe, one cycle per data byte
//   wr_addr      - registered RAM write address
//   wr_data      - registered RAM write data
//   cpu_hold     - keep CPU (sequencer + PC) in reset
//   done         - load completed with good checksum
//   error        - load failed (bad length, bad checksum, abort)
//   bytes_loaded - data bytes written in the current or last load
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | not programming, CPU runs
// LEN   | waiting for the length byte
// DATA  | writing data bytes to consecutive addresses
// CHK   | waiting for the checksum byte
// DONE  | load good, held until prog_mode drops
// ERR   | load failed or aborted, held until prog_mode drops
module ram_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   bytes_loaded
);

  import sap_pkg::*;

  localparam logic [DATA_W-1:0] MAX_LEN = DATA_W'(2**ADDR_W);

  loader_state_t     state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  // One bit wider than the address so N = depth ends at index = depth
  // instead of wrapping back to address 0.
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   idx_inc;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              xfer;

  assign in_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
  assign xfer     = in_valid && in_ready;
  assign idx_inc  = idx_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    // Dropping prog_mode mid-frame wins over a same-cycle transfer, so an
    // aborted frame never issues another write.
    unique case (state_q)
      IDLE: if (prog_mode) state_d = LEN;
      LEN: begin
        if (!prog_mode) begin
          state_d = ERR;
        end else if (xfer) begin
          if (in_data == '0 || in_data > MAX_LEN) begin
            state_d = ERR;
          end else begin
            len_d   = in_data[ADDR_W:0];
            idx_d   = '0;
            sum_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (!prog_mode) begin
          state_d = ERR;
        end else if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[ADDR_W-1:0];
          wr_data_d = in_data;
          sum_d     = sum_q + in_data;
          idx_d     = idx_inc;
          if (idx_inc == len_q) state_d = CHK;
        end
      end
      CHK: begin
        if (!prog_mode) begin
          state_d = ERR;
        end else if (xfer) begin
          state_d = (in_data == sum_q) ? DONE : ERR;
        end
      end
      DONE, ERR: if (!prog_mode) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cpu_hold     = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);
  assign bytes_loaded = idx_q;

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       prog_mode;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [4:0] bytes_loaded;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  ram_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .prog_mode(prog_mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error),
    .bytes_loaded(bytes_loaded)
  );

  // Write scoreboard: every observed write must match the next expected one.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%02h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
  end

  // Presents one byte (optionally after a one-cycle in_valid gap) and returns
  // #1 after the accepting edge; a byte never accepted counts as a failure.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: byte %02h not accepted, expected acceptance", b);
    end
  endtask

  task automatic send_data(input logic [7:0] b, input logic [3:0] addr, input bit gap);
    wr_t e;
    e.addr = addr;
    e.data = b;
    exp_q.push_back(e);
    send_byte(b, gap);
  endtask

  task automatic enter_prog;
    prog_mode = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; prog_mode = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, wr_en, cpu_hold, done, error} !== 5'b0 || wr_addr !== 4'd0 ||
        wr_data !== 8'h00 || bytes_loaded !== 5'd0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b wen=%b hold=%b done=%b err=%b addr=%0d data=%02h bl=%0d, expected all 0",
               in_ready, wr_en, cpu_hold, done, error, wr_addr, wr_data, bytes_loaded);
    end
    prog_mode = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got cpu_hold=%b, expected 0", cpu_hold);
    end
  endtask

  task automatic test_good_load;
    logic [7:0] d [5] = '{8'h19, 8'h70, 8'h1A, 8'h10, 8'hF0};
    enter_prog();
    checks++;
    if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL len_entry: got in_ready=%b cpu_hold=%b, expected 1 1", in_ready, cpu_hold);
    end
    send_byte(8'h05, 1'b0);
    for (int i = 0; i < 5; i++) send_data(d[i], 4'(i), 1'b0);
    send_byte(8'hA3, 1'b0);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || bytes_loaded !== 5'd5) begin
      errors++;
      $display("FAIL good_done: got done=%b error=%b bytes=%0d, expected 1 0 5", done, error, bytes_loaded);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL good_writes: got %0d writes missing, expected 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cpu_hold !== 1'b1 || done !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: got cpu_hold=%b done=%b in_ready=%b, expected 1 1 0", cpu_hold, done, in_ready);
    end
    prog_mode = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cpu_hold !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL good_release: got cpu_hold=%b done=%b, expected 0 0", cpu_hold, done);
    end
  endtask

  task automatic test_bad_checksum;
    logic [7:0] d [5] = '{8'h19, 8'h70, 8'h1A, 8'h10, 8'hF0};
    enter_prog();
    send_byte(8'h05, 1'b0);
    for (int i = 0; i < 5; i++) send_data(d[i], 4'(i), 1'b0);
    send_byte(8'hA2, 1'b0);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bad_chk: got error=%b done=%b pending=%0d, expected 1 0 0", error, done, exp_q.size());
    end
    prog_mode = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_len;
    logic [7:0] lens [2] = '{8'h00, 8'h11};
    for (int k = 0; k < 2; k++) begin
      enter_prog();
      send_byte(lens[k], 1'b0);
      checks++;
      if (error !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL illegal_len_%02h: got error=%b done=%b in_ready=%b, expected 1 0 0",
                 lens[k], error, done, in_ready);
      end
      // Any write would be flagged by the scoreboard, which holds nothing.
      repeat (2) @(posedge clk);
      prog_mode = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_throttled;
    enter_prog();
    send_byte(8'h10, 1'b1);
    for (int i = 0; i < 16; i++) send_data(8'(i), 4'(i), 1'b1);
    send_byte(8'h78, 1'b1);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || bytes_loaded !== 5'd16) begin
      errors++;
      $display("FAIL full_done: got done=%b error=%b bytes=%0d, expected 1 0 16", done, error, bytes_loaded);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_writes: got %0d writes missing, expected 0", exp_q.size());
    end
    prog_mode = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    enter_prog();
    send_byte(8'h05, 1'b0);
    for (int i = 0; i < 3; i++) send_data(8'hC0 + 8'(i), 4'(i), 1'b0);
    prog_mode = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (error !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL abort_err: got error=%b cpu_hold=%b, expected 1 1", error, cpu_hold);
    end
    @(posedge clk); #1;
    checks++;
    if (cpu_hold !== 1'b0 || error !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_idle: got cpu_hold=%b error=%b pending=%0d, expected 0 0 0",
               cpu_hold, error, exp_q.size());
    end
  endtask

  task automatic test_async_reset;
    enter_prog();
    send_byte(8'h04, 1'b0);
    send_data(8'h11, 4'd0, 1'b0);
    send_data(8'h22, 4'd1, 1'b0);
    // Second write strobe is live now; reset lands between edges.
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (cpu_hold !== 1'b0 || in_ready !== 1'b0 || wr_en !== 1'b0 || bytes_loaded !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: got cpu_hold=%b in_ready=%b wr_en=%b bytes=%0d, expected 0 0 0 0",
               cpu_hold, in_ready, wr_en, bytes_loaded);
    end
    exp_q.delete();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL restart_len: got in_ready=%b cpu_hold=%b, expected 1 1", in_ready, cpu_hold);
    end
    send_byte(8'h01, 1'b0);
    send_data(8'h42, 4'd0, 1'b0);
    send_byte(8'h42, 1'b0);
    checks++;
    if (done !== 1'b1 || bytes_loaded !== 5'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_load: got done=%b bytes=%0d pending=%0d, expected 1 1 0",
               done, bytes_loaded, exp_q.size());
    end
    prog_mode = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_illegal_len();
    test_full_throttled();
    test_abort();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
